// File: rtl/fir_pkg.sv
// Shared types and helpers for the sequential FIR filter.
// The saturate helper works on a wide signed value and clamps it to any narrower signed width.
package fir_pkg;

    typedef enum logic [1:0] {
        FIR_IDLE,
        FIR_MAC,
        FIR_OUT
    } fir_state_t;

    typedef enum logic {
        MODE_FILTER,
        MODE_BYPASS
    } fir_mode_t;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    hit;
        logic signed [SAT_W-1:0] value;
    } sat_result_t;

    function automatic sat_result_t saturate(input logic signed [SAT_W-1:0] value,
                                             input int                      width);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_result_t             r;
        max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v   = -max_v - 64'sd1;
        r.hit   = 1'b0;
        r.value = value;
        if (value > max_v) begin
            r.hit   = 1'b1;
            r.value = max_v;
        end else if (value < min_v) begin
            r.hit   = 1'b1;
            r.value = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file for the FIR filter: one write port that only
// takes effect while the filter is idle, and one combinational indexed read port.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_TAPS    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           idle,
    input  logic                           we,
    input  logic [$clog2(NUM_TAPS)-1:0]    waddr,
    input  logic signed [COEFF_WIDTH-1:0]  wdata,
    input  logic [$clog2(NUM_TAPS)-1:0]    raddr,
    output logic signed [COEFF_WIDTH-1:0]  rdata
);

    logic signed [COEFF_WIDTH-1:0] coeff_q [NUM_TAPS];

    // Writes outside IDLE are dropped so a running computation sees a frozen bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coeff_q[i] <= '0;
            end
        end else if (we && idle) begin
            coeff_q[waddr] <= wdata;
        end
    end

    assign rdata = coeff_q[raddr];

endmodule

// File: rtl/fir_filter_seq.sv
// Sequential FIR filter: NUM_TAPS-deep delay line, one time-shared MAC,
// arithmetic-shift scaling with saturation, bypass mode and valid/ready on both sides.
module fir_filter_seq
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_TAPS    = 8,
    parameter int SHIFT       = COEFF_WIDTH - 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mode,
    input  logic                           coeff_we,
    input  logic [$clog2(NUM_TAPS)-1:0]    coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0]  coeff_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [DATA_WIDTH-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_WIDTH-1:0]   out_data,
    output logic                           busy,
    output logic [15:0]                    sat_count
);

    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
    localparam int IDX_W  = $clog2(NUM_TAPS + 1);

    fir_state_t                    state;
    fir_mode_t                     mode_q;
    logic signed [DATA_WIDTH-1:0]  x [NUM_TAPS];
    logic [IDX_W-1:0]              tap_idx;
    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       acc_next;
    logic [ADDR_W-1:0]             tap_sel;
    logic signed [DATA_WIDTH-1:0]  x_sel;
    logic signed [COEFF_WIDTH-1:0] c_sel;
    logic signed [PROD_W-1:0]      x_ext;
    logic signed [PROD_W-1:0]      c_ext;
    logic signed [PROD_W-1:0]      product;
    logic signed [SAT_W-1:0]       acc_wide;
    logic signed [SAT_W-1:0]       acc_shifted;
    sat_result_t                   sat;
    logic                          accept;
    logic                          mac_done;
    logic                          unused_sat_bits;

    assign in_ready = (state == FIR_IDLE);
    assign busy     = (state != FIR_IDLE);
    assign accept   = in_valid && in_ready;
    assign mac_done = (tap_idx == IDX_W'(NUM_TAPS));

    fir_coeff_bank #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .NUM_TAPS    (NUM_TAPS)
    ) u_coeff_bank (
        .clk   (clk),
        .rst   (rst),
        .idle  (in_ready),
        .we    (coeff_we),
        .waddr (coeff_addr),
        .wdata (coeff_data),
        .raddr (tap_sel),
        .rdata (c_sel)
    );

    // The tap index runs one past the last tap; that extra cycle scales and saturates.
    always_comb begin
        tap_sel = '0;
        if (!mac_done) begin
            tap_sel = tap_idx[ADDR_W-1:0];
        end
    end

    assign x_sel    = x[tap_sel];
    assign x_ext    = {{COEFF_WIDTH{x_sel[DATA_WIDTH-1]}}, x_sel};
    assign c_ext    = {{DATA_WIDTH{c_sel[COEFF_WIDTH-1]}}, c_sel};
    assign product  = x_ext * c_ext;
    assign acc_next = acc + {{(ACC_W - PROD_W){product[PROD_W-1]}}, product};

    assign acc_wide    = {{(SAT_W - ACC_W){acc[ACC_W-1]}}, acc};
    assign acc_shifted = acc_wide >>> SHIFT;
    assign sat         = saturate(acc_shifted, DATA_WIDTH);

    assign unused_sat_bits = ^sat.value[SAT_W-1:DATA_WIDTH];

    // Delay line shifts on every accepted sample, bypassed ones included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                x[i] <= '0;
            end
        end else if (accept) begin
            x[0] <= in_data;
            for (int i = 1; i < NUM_TAPS; i++) begin
                x[i] <= x[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FIR_IDLE;
            mode_q    <= MODE_FILTER;
            tap_idx   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_count <= '0;
        end else begin
            case (state)
                FIR_IDLE: begin
                    if (accept) begin
                        mode_q <= fir_mode_t'(mode);
                        if (fir_mode_t'(mode) == MODE_BYPASS) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                            state     <= FIR_OUT;
                        end else begin
                            acc     <= '0;
                            tap_idx <= '0;
                            state   <= FIR_MAC;
                        end
                    end
                end
                FIR_MAC: begin
                    if (mac_done) begin
                        out_data  <= sat.value[DATA_WIDTH-1:0];
                        out_valid <= 1'b1;
                        state     <= FIR_OUT;
                        if (sat.hit && (mode_q == MODE_FILTER) && (sat_count != 16'hFFFF)) begin
                            sat_count <= sat_count + 16'd1;
                        end
                    end else begin
                        acc     <= acc_next;
                        tap_idx <= tap_idx + IDX_W'(1);
                    end
                end
                FIR_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= FIR_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= FIR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_seq.sv
// Self-checking bench for fir_filter_seq: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a plain-arithmetic reference model.
module tb_fir_filter_seq;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int NT = 4;
    localparam int SH = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 mode = 1'b0;
    logic                 coeff_we = 1'b0;
    logic [1:0]           coeff_addr = '0;
    logic signed [CW-1:0] coeff_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_data;
    logic                 busy;
    logic [15:0]          sat_count;

    int compared   = 0;
    int mismatched = 0;

    longint refX [NT];
    longint refC [NT];
    int     refSat;

    typedef struct {
        bit m;
        int data;
        int expOut;
        int expSat;
    } vec_t;

    vec_t vecs [13];

    fir_filter_seq #(
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (CW),
        .NUM_TAPS    (NT),
        .SHIFT       (SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .coeff_we   (coeff_we),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NT; i++) begin
            refX[i] = 0;
            refC[i] = 0;
        end
        refSat = 0;
    endtask

    // Reference: y = clamp(floor(sum(x[i]*c[i]) / 2^SH)) over the last NT samples.
    task automatic modelAccept(input bit m, input int data, output int expOut);
        longint sum;
        longint scaled;
        for (int i = NT - 1; i > 0; i--) begin
            refX[i] = refX[i-1];
        end
        refX[0] = data;
        if (m) begin
            expOut = data;
        end else begin
            sum = 0;
            for (int i = 0; i < NT; i++) begin
                sum += refX[i] * refC[i];
            end
            scaled = sum >>> SH;
            if (scaled > 32767) begin
                expOut = 32767;
                if (refSat < 65535) refSat++;
            end else if (scaled < -32768) begin
                expOut = -32768;
                if (refSat < 65535) refSat++;
            end else begin
                expOut = int'(scaled);
            end
        end
    endtask

    task automatic writeCoeff(input int addr, input int value);
        @(negedge clk);
        coeff_we   = 1'b1;
        coeff_addr = 2'(addr);
        coeff_data = 16'(value);
        @(posedge clk);
        @(negedge clk);
        coeff_we = 1'b0;
        refC[addr] = value;
    endtask

    // One full transaction: optional same-cycle coefficient write at accept, optional
    // writes attempted during MAC/OUT, optional backpressure hold, then handshake.
    task automatic applyStimulus(input bit m, input int data, input int hold,
                                 input bit macWrite, input bit accWrite,
                                 input int wAddr, input int wData, output int got);
        int expOut;
        int lat;
        int waitCnt;
        @(negedge clk);
        waitCnt = 0;
        while (!in_ready && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
        if (accWrite) begin
            coeff_we   = 1'b1;
            coeff_addr = 2'(wAddr);
            coeff_data = 16'(wData);
            refC[wAddr] = wData;
        end
        modelAccept(m, data, expOut);
        mode     = m;
        in_data  = 16'(data);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        coeff_we = macWrite;
        if (macWrite) begin
            coeff_addr = 2'(wAddr);
            coeff_data = 16'(wData);
        end
        checkOutput("busy_after_accept", busy, 1);
        checkOutput("in_ready_after_accept", in_ready, 0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 50);
        checkOutput(m ? "latency_bypass" : "latency_filter", lat, m ? 1 : NT + 1);
        got = out_data;
        checkOutput("out_data", got, expOut);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_out_data", out_data, expOut);
            checkOutput("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        coeff_we  = 1'b0;
        checkOutput("out_valid_after_hs", out_valid, 0);
        checkOutput("in_ready_after_hs", in_ready, 1);
        checkOutput("sat_count", sat_count, refSat);
    endtask

    initial begin
        int got;
        int coeffsA [NT];

        coeffsA = '{256, 512, -256, 128};
        vecs[0]  = '{0, 100, 100, 0};
        vecs[1]  = '{0, 0, 200, 0};
        vecs[2]  = '{0, 0, -100, 0};
        vecs[3]  = '{0, 0, 50, 0};
        vecs[4]  = '{0, 0, 0, 0};
        vecs[5]  = '{0, 32767, 32767, 1};
        vecs[6]  = '{0, 32767, 32767, 2};
        vecs[7]  = '{0, 32767, 32767, 3};
        vecs[8]  = '{0, 32767, 32767, 4};
        vecs[9]  = '{0, -32768, 32767, 5};
        vecs[10] = '{0, -32768, -256, 5};
        vecs[11] = '{0, -32768, -32768, 6};
        vecs[12] = '{0, -32768, -32768, 7};

        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_sat_count", sat_count, 0);

        for (int k = 0; k < 13; k++) begin
            if (k == 0) begin
                for (int a = 0; a < NT; a++) writeCoeff(a, coeffsA[a]);
            end
            if (k == 5) begin
                for (int a = 0; a < NT; a++) writeCoeff(a, 32767);
            end
            applyStimulus(vecs[k].m, vecs[k].data, 0, 1'b0, 1'b0, 0, 0, got);
            checkOutput("table_out", got, vecs[k].expOut);
            checkOutput("table_sat", sat_count, vecs[k].expSat);
        end

        $display("[TB] backpressure hold");
        applyStimulus(1'b0, 1000, 10, 1'b0, 1'b0, 0, 0, got);

        $display("[TB] bypass then seamless return to filter");
        applyStimulus(1'b1, 1234, 0, 1'b0, 1'b0, 0, 0, got);
        checkOutput("bypass_out", got, 1234);
        writeCoeff(0, 0);
        writeCoeff(1, 256);
        writeCoeff(2, 0);
        writeCoeff(3, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, got);
        checkOutput("filter_after_bypass", got, 1234);

        $display("[TB] coefficient writes during MAC/OUT are ignored");
        applyStimulus(1'b0, 40, 0, 1'b0, 1'b0, 0, 0, got);
        applyStimulus(1'b0, 60, 2, 1'b1, 1'b0, 1, 1000, got);
        checkOutput("mac_write_ignored", got, 40);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 0, got);
        checkOutput("coeff_still_old", got, 60);

        $display("[TB] coefficient write together with accept");
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 2, 512, got);
        checkOutput("same_cycle_write", got, 120);

        $display("[TB] randomized traffic");
        for (int r = 0; r < 40; r++) begin
            int d;
            int cv;
            bit m;
            if ($urandom_range(0, 3) == 0) begin
                cv = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                                 : int'($urandom_range(0, 1200)) - 600;
                writeCoeff(int'($urandom_range(0, NT - 1)), cv);
            end
            m  = ($urandom_range(0, 4) == 0);
            d  = int'($urandom_range(0, 65535)) - 32768;
            cv = int'($urandom_range(0, 1200)) - 600;
            applyStimulus(m, d, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), int'($urandom_range(0, NT - 1)), cv, got);
        end

        $display("[TB] reset in the middle of MAC");
        writeCoeff(0, 300);
        applyStimulus(1'b0, 5000, 0, 1'b0, 1'b0, 0, 0, got);
        @(negedge clk);
        mode     = 1'b0;
        in_data  = 16'sd777;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("midmac_out_valid", out_valid, 0);
        checkOutput("midmac_busy", busy, 0);
        checkOutput("midmac_in_ready", in_ready, 1);
        checkOutput("midmac_out_data", out_data, 0);
        checkOutput("midmac_sat_count", sat_count, 0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b0, 500, 0, 1'b0, 1'b0, 0, 0, got);
        checkOutput("zero_coeff_0", got, 0);
        applyStimulus(1'b0, -700, 0, 1'b0, 1'b0, 0, 0, got);
        checkOutput("zero_coeff_1", got, 0);
        applyStimulus(1'b0, 900, 0, 1'b0, 1'b0, 0, 0, got);
        checkOutput("zero_coeff_2", got, 0);
        applyStimulus(1'b0, 31000, 0, 1'b0, 1'b0, 0, 0, got);
        checkOutput("zero_coeff_3", got, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
